// File: rtl/prog_pkg.sv
// Shared definitions for the programming loader: header magic bit, FSM states
// and the instruction byte-count derivation.
package prog_pkg;

  localparam int HDR_MAGIC = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    LEN  = 2'd2,
    DATA = 2'd3
  } state_e;

  function automatic int instr_bytes(input int instr_width);
    return instr_width / 8;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream programming loader: parses HEADER/ADDR/LEN/DATA frames and emits
// one write strobe per little-endian assembled instruction.
module prog_loader
  import prog_pkg::*;
#(
  parameter int CORES       = 8,
  parameter int LOG_CORES   = 3,
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   abort,
  output logic                   we,
  output logic [LOG_CORES-1:0]   sel,
  output logic [PC_WIDTH-1:0]    waddr,
  output logic [INSTR_WIDTH-1:0] wdata,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int INSTR_BYTES = instr_bytes(INSTR_WIDTH);
  localparam int BW          = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(INSTR_BYTES - 1);

  if (LOG_CORES > 7 || (1 << LOG_CORES) < CORES || PC_WIDTH > 8 || (INSTR_WIDTH % 8) != 0) begin : g_bad_params
    $error("prog_loader: unsupported parameter combination");
  end

  state_e                 state_q;
  logic                   in_ready_q;
  logic                   we_q;
  logic                   frame_done_q;
  logic [LOG_CORES-1:0]   core_q;
  logic [LOG_CORES-1:0]   sel_q;
  logic [PC_WIDTH-1:0]    addr_q;
  logic [PC_WIDTH-1:0]    waddr_q;
  logic [7:0]             cnt_q;
  logic [BW-1:0]          byte_idx_q;
  logic [INSTR_WIDTH-1:0] asm_q;
  logic [INSTR_WIDTH-1:0] asm_d;
  logic [INSTR_WIDTH-1:0] wdata_q;
  logic                   take;

  assign take = in_valid && in_ready_q;

  // Current byte merged into the assembly register, so the final byte can be
  // written out in the same edge it arrives.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      core_q       <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      waddr_q      <= '0;
      cnt_q        <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      wdata_q      <= '0;
    end else begin
      in_ready_q   <= 1'b1;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        byte_idx_q <= '0;
      end else if (take) begin
        case (state_q)
          IDLE: begin
            if (in_data[HDR_MAGIC]) begin
              core_q  <= in_data[LOG_CORES-1:0];
              state_q <= ADDR;
            end
          end
          ADDR: begin
            addr_q  <= in_data[PC_WIDTH-1:0];
            state_q <= LEN;
          end
          LEN: begin
            byte_idx_q <= '0;
            if (in_data == 8'd0) begin
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              cnt_q   <= in_data;
              state_q <= DATA;
            end
          end
          DATA: begin
            asm_q <= asm_d;
            if (byte_idx_q == LAST_BYTE) begin
              wdata_q    <= asm_d;
              waddr_q    <= addr_q;
              sel_q      <= core_q;
              we_q       <= 1'b1;
              addr_q     <= addr_q + PC_WIDTH'(1);
              cnt_q      <= cnt_q - 8'd1;
              byte_idx_q <= '0;
              if (cnt_q == 8'd1) begin
                frame_done_q <= 1'b1;
                state_q      <= IDLE;
              end
            end else begin
              byte_idx_q <= byte_idx_q + BW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign we         = we_q;
  assign sel        = sel_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level model of expected writes
// plus directed literal checks.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        abort = 1'b0;
  logic        in_ready;
  logic        we;
  logic [2:0]  sel;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        frame_done;

  prog_loader #(.CORES(8), .LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .we(we), .sel(sel), .waddr(waddr),
    .wdata(wdata), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    bit          done;
    logic [2:0]  sel;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] wbuf[$];
  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;
  int          we_cyc[$];
  logic [7:0]  waddr_log[$];
  logic [2:0]  last_sel = '0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        last_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every strobe or frame completion must match the next predicted event.
  always @(negedge clk) begin
    if (rst_n && (we || frame_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {62'd0, we, frame_done}, 64'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("we", we, e.wr);
        chk("frame_done", frame_done, e.done);
        chk("event_cycle", cyc, e.cyc);
        if (e.wr) begin
          chk("sel", sel, e.sel);
          chk("waddr", waddr, e.addr);
          chk("wdata", wdata, e.data);
        end
      end
      if (we) begin
        we_count++;
        we_cyc.push_back(cyc);
        waddr_log.push_back(waddr);
        last_sel   = sel;
        last_waddr = waddr;
        last_wdata = wdata;
        last_done  = frame_done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] addr, input bit gapped);
    int n;
    logic [31:0] w;
    n = wbuf.size();
    send(hdr);
    if (!hdr[7]) return;
    send(addr);
    send(8'(n));
    if (n == 0) exp_q.push_back('{wr: 1'b0, done: 1'b1, sel: 3'd0, addr: 8'd0, data: 32'd0, cyc: cyc});
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      for (int k = 0; k < 4; k++) begin
        if (gapped && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        send(w[8*k +: 8]);
      end
      exp_q.push_back('{wr: 1'b1, done: (i == n - 1), sel: hdr[2:0],
                        addr: addr + 8'(i), data: w, cyc: cyc});
    end
  endtask

  task automatic flush(input string name);
    idle(4);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_sel", sel, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    #5 rst_n = 1'b1;
    chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1);

    // Single instruction
    wbuf = {};
    wbuf.push_back(32'h12345678);
    send_frame(8'h82, 8'h10, 1'b0);
    flush("t1_pending");
    chk("t1_sel", last_sel, 3'd2);
    chk("t1_waddr", last_waddr, 8'h10);
    chk("t1_wdata", last_wdata, 32'h12345678);
    chk("t1_done_with_we", last_done, 1'b1);
    chk("t1_busy_idle", busy, 0);

    // Wrap-around, followed immediately by another frame
    we_cyc = {};
    waddr_log = {};
    wbuf = {};
    wbuf.push_back(32'hDEADBEEF);
    wbuf.push_back(32'h0BADF00D);
    send_frame(8'h80, 8'hFF, 1'b0);
    wbuf = {};
    wbuf.push_back(32'hCAFEF00D);
    send_frame(8'h87, 8'h40, 1'b0);
    flush("t2_pending");
    chk("t2_we_count", we_cyc.size(), 3);
    if (we_cyc.size() >= 2) begin
      chk("t2_spacing", we_cyc[1] - we_cyc[0], 4);
      chk("t2_addr0", waddr_log[0], 8'hFF);
      chk("t2_addr1", waddr_log[1], 8'h00);
    end
    chk("t2_b2b_sel", last_sel, 3'd7);
    chk("t2_b2b_wdata", last_wdata, 32'hCAFEF00D);

    // Bad header then zero-length frame
    base = we_count;
    send(8'h05);
    chk("t3_bad_hdr_busy", busy, 0);
    wbuf = {};
    send_frame(8'h81, 8'h00, 1'b0);
    flush("t3_pending");
    chk("t3_no_we", we_count - base, 0);
    chk("t3_busy_idle", busy, 0);

    // Abort mid-word
    base = we_count;
    send(8'h83); send(8'h20); send(8'h03); send(8'hAA); send(8'hBB);
    chk("t4_busy_before_abort", busy, 1);
    abort = 1'b1;
    send(8'hCC);
    abort = 1'b0;
    chk("t4_busy_after_abort", busy, 0);
    flush("t4_pending");
    chk("t4_no_we", we_count - base, 0);
    wbuf = {};
    wbuf.push_back(32'h11223344);
    send_frame(8'h83, 8'h20, 1'b0);
    flush("t4b_pending");
    chk("t4_clean_wdata", last_wdata, 32'h11223344);
    chk("t4_clean_waddr", last_waddr, 8'h20);

    // Gapped stream
    base = we_count;
    wbuf = {};
    wbuf.push_back(32'hA1B2C3D4);
    wbuf.push_back(32'h01020304);
    wbuf.push_back(32'hFFEEDDCC);
    send_frame(8'h84, 8'h30, 1'b1);
    flush("t5_pending");
    chk("t5_we_count", we_count - base, 3);
    chk("t5_last_waddr", last_waddr, 8'h32);

    // Reset mid-frame with a pending strobe
    send(8'h86); send(8'h50); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_we", we, 0);
    chk("t6_sel", sel, 0);
    chk("t6_waddr", waddr, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_in_ready", in_ready, 0);
    idle(1);
    #4 rst_n = 1'b1;
    chk("t6_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("t6_ready_after_edge", in_ready, 1);
    wbuf = {};
    wbuf.push_back(32'hA5A55A5A);
    send_frame(8'h81, 8'h07, 1'b0);
    flush("t6_pending");
    chk("t6_post_wdata", last_wdata, 32'hA5A55A5A);
    chk("t6_post_waddr", last_waddr, 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
